// File: rtl/pipelined_adder_pkg.sv
// Shared constants and helpers for the pipelined adder.
package pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_SEG   = 4;

  function automatic int stage_count(input int width, input int seg);
    return (seg < 1) ? 1 : width / seg;
  endfunction

endpackage

// File: rtl/pipelined_adder_segment.sv
// One SEG-bit combinational ripple slice of the pipelined adder.
module adder_segment
  import pipelined_adder_pkg::*;
#(
  parameter int SEG = DEFAULT_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  logic [SEG:0] total;

  assign total       = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
  assign {cout, sum} = total;

endmodule

// File: rtl/pipelined_adder.sv
// Carry-segmented pipelined adder with valid/ready flow control.
// Optional PIPELINED_ADDER_SUB_EN adds a 'sub' input for two's-complement a-b.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SEG   = DEFAULT_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int STAGES = stage_count(WIDTH, SEG);
  localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'((64'd1 << SEG) - 64'd1);

  if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a non-zero multiple of SEG");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] cry;
  logic [WIDTH-1:0]  opa  [STAGES];
  logic [WIDTH-1:0]  opb  [STAGES];
  logic [WIDTH-1:0]  psum [STAGES];

  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic             src_c [STAGES];
  logic             src_v [STAGES];
  logic [SEG-1:0]   seg_sum [STAGES];
  logic             seg_co  [STAGES];
  logic [WIDTH-1:0] nxt_s   [STAGES];

  // Subtraction folds into the adder as a + ~b + 1 before the first stage.
`ifdef PIPELINED_ADDER_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  assign out_valid = vld[STAGES-1];
  assign adv       = out_ready || !out_valid;
  assign in_ready  = adv;
  assign sum       = out_valid ? psum[STAGES-1] : '0;
  assign co        = out_valid && cry[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign src_a[k] = a;
      assign src_b[k] = b_eff;
      assign src_s[k] = '0;
      assign src_c[k] = cin_eff;
      assign src_v[k] = in_valid;
    end else begin : g_next
      assign src_a[k] = opa[k-1];
      assign src_b[k] = opb[k-1];
      assign src_s[k] = psum[k-1];
      assign src_c[k] = cry[k-1];
      assign src_v[k] = vld[k-1];
    end

    adder_segment #(.SEG(SEG)) u_seg (
      .a    (src_a[k][k*SEG +: SEG]),
      .b    (src_b[k][k*SEG +: SEG]),
      .cin  (src_c[k]),
      .sum  (seg_sum[k]),
      .cout (seg_co[k])
    );

    assign nxt_s[k] = (src_s[k] & ~(SEG_MASK << (k*SEG)))
                    | (WIDTH'(seg_sum[k]) << (k*SEG));
  end

  // The whole pipe moves as one; a stall freezes every stage including the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      cry <= '0;
      for (int k = 0; k < STAGES; k++) begin
        opa[k]  <= '0;
        opb[k]  <= '0;
        psum[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld[k]  <= src_v[k];
        cry[k]  <= seg_co[k];
        opa[k]  <= src_a[k];
        opb[k]  <= src_b[k];
        psum[k] <= nxt_s[k];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=16, SEG=4).
module tb_pipelined_adder;

  localparam int WIDTH   = 16;
  localparam int SEG     = 4;
  localparam int LATENCY = WIDTH / SEG;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             out_valid;
  logic             out_ready;

  int checks = 0;
  int passed = 0;
  logic [WIDTH:0] exp_q[$];

  pipelined_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef PIPELINED_ADDER_SUB_EN
    .sub       (sub),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .co        (co),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the full WIDTH+1 result.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic c, input logic s);
    logic [WIDTH-1:0] ny;
    ny = ~y;
    if (s) return {1'b0, x} + {1'b0, ny} + (WIDTH+1)'(1);
    return {1'b0, x} + {1'b0, y} + (WIDTH+1)'(c);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input logic cv, input logic vv, input logic rdy);
    a         = av;
    b         = bv;
    cin       = cv;
    in_valid  = vv;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  // Called one step after the accepting edge with an empty pipe.
  task automatic measureLatency(input string name);
    int lat;
    lat      = 1;
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput(name, lat, LATENCY);
  endtask

  // Monitor: samples the handshakes that the next rising edge will complete.
  always @(negedge clk) begin
    logic [WIDTH:0] e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      checkOutput("in_ready_rule", {31'd0, in_ready}, {31'd0, out_ready || !out_valid});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("result", 32'({co, sum}), 32'(e));
        end
      end else if (!out_valid) begin
        checkOutput("idle_zero", 32'({co, sum}), 32'd0);
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [WIDTH:0] held;
    rst_n     = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #2;
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_sum_co", 32'({co, sum}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] directed: wrap-around and latency");
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1);
    measureLatency("latency_after_reset");
    checkOutput("ffff_plus_1", 32'({co, sum}), 32'h0001_0000);
    idle(3);

    applyStimulus(16'h8000, 16'h8000, 1'b1, 1'b1, 1'b1);
    measureLatency("latency_8000");
    checkOutput("8000_plus_8000_c1", 32'({co, sum}), 32'h0001_0001);
    idle(3);
    applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b1, 1'b1);
    measureLatency("latency_1234");
    checkOutput("1234_plus_1111", 32'({co, sum}), 32'h0000_2345);
    idle(3);

    $display("[TB] directed: back-to-back");
    applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b1, 1'b1);
    applyStimulus(16'h00F0, 16'h0010, 1'b1, 1'b1, 1'b1);
    applyStimulus(16'hABCD, 16'h5433, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("b2b_valid_%0d", i), {31'd0, out_valid}, {31'd0, (i < 3)});
    end
    idle(3);

    $display("[TB] directed: output stall");
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b1, 1'b1);
    applyStimulus(16'h3333, 16'h4444, 1'b1, 1'b1, 1'b1);
    applyStimulus(16'hF000, 16'h1000, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    held      = {co, sum};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("stall_hold", 32'({co, sum}), 32'(held));
    end
    out_ready = 1'b1;
    idle(8);

    $display("[TB] directed: reset mid-flight");
    applyStimulus(16'h0F0F, 16'h0101, 1'b0, 1'b1, 1'b1);
    applyStimulus(16'h7777, 16'h0009, 1'b1, 1'b1, 1'b1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midreset_sum_co", 32'({co, sum}), 32'd0);
    checkOutput("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checkOutput("no_stale_result", {31'd0, out_valid}, 32'd0);
    end
    applyStimulus(16'h2468, 16'h1357, 1'b1, 1'b1, 1'b1);
    measureLatency("latency_post_reset");
    idle(3);

`ifdef PIPELINED_ADDER_SUB_EN
    $display("[TB] directed: subtraction");
    sub = 1'b1;
    applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
    measureLatency("latency_sub");
    checkOutput("5_minus_7", 32'({co, sum}), 32'h0000_FFFE);
    idle(3);
    applyStimulus(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1);
    measureLatency("latency_sub2");
    checkOutput("7_minus_5", 32'({co, sum}), 32'h0001_0002);
    sub = 1'b0;
    idle(3);
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
`ifdef PIPELINED_ADDER_SUB_EN
      sub = 1'($urandom_range(0, 1));
`endif
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end
    idle(12);
    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
